// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory interface: sequences async SRAM reads/writes with a fixed number of
// wait states and decodes one memory-mapped I/O word (switches / hex display).
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF,
    parameter int unsigned SRAM_AW     = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               MEM_RD,
    input  logic               MEM_WE,
    input  logic [15:0]        MAR_addr,
    input  logic [15:0]        MDR_val,
    input  logic [15:0]        Switches,
    output logic [15:0]        Data_to_CPU,
    output logic               R,
    output logic [15:0]        Hex_out,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_din,
    output logic [15:0]        sram_dout,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdat_q, wdat_d;
    logic               op_q, op_d;
    logic               io_q, io_d;
    logic [15:0]        data_cpu_q, data_cpu_d;
    logic               r_q, r_d;
    logic [15:0]        hex_q, hex_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        sram_dout_q, sram_dout_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               lb_n_q, lb_n_d;
    logic               ub_n_q, ub_n_d;
    logic               req_s;

    assign req_s = MEM_RD | MEM_WE;

    // Transaction sequencing, request capture and read/IO data update.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        op_d       = op_q;
        io_d       = io_q;
        data_cpu_d = data_cpu_q;
        hex_d      = hex_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    addr_d = MAR_addr;
                    wdat_d = MDR_val;
                    op_d   = MEM_WE;
                    io_d   = (MAR_addr == IO_ADDR);
                    if (MAR_addr == IO_ADDR) begin
                        state_d = S_DONE;
                        if (MEM_WE) begin
                            hex_d = MDR_val;
                        end else begin
                            data_cpu_d = Switches;
                        end
                    end else begin
                        state_d = S_SETUP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d    = S_WAIT;
                wait_cnt_d = 4'd0;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_DONE;
                    wait_cnt_d = 4'd0;
                    if (!op_q) begin
                        data_cpu_d = sram_din;
                    end else begin
                        data_cpu_d = data_cpu_q;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!req_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // SRAM pins are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        r_d         = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_dout_d = sram_dout_q;
        case (state_d)
            S_SETUP, S_WAIT: begin
                ce_n_d      = 1'b0;
                lb_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                sram_addr_d = {{(SRAM_AW-16){1'b0}}, addr_d};
                if (op_d) begin
                    dq_oe_d     = 1'b1;
                    sram_dout_d = wdat_d;
                    we_n_d      = (state_d == S_WAIT) ? 1'b0 : 1'b1;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            S_DONE: begin
                r_d     = 1'b1;
                // Keep driving DQ one cycle past the we_n rising edge for data hold.
                dq_oe_d = op_d & ~io_d;
            end
            default: begin
                r_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= 16'd0;
            wdat_q      <= 16'd0;
            op_q        <= 1'b0;
            io_q        <= 1'b0;
            data_cpu_q  <= 16'd0;
            r_q         <= 1'b0;
            hex_q       <= 16'd0;
            sram_addr_q <= '0;
            sram_dout_q <= 16'd0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            op_q        <= op_d;
            io_q        <= io_d;
            data_cpu_q  <= data_cpu_d;
            r_q         <= r_d;
            hex_q       <= hex_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
        end
    end

    assign Data_to_CPU = data_cpu_q;
    assign R           = r_q;
    assign Hex_out     = hex_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dout   = sram_dout_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_ub_n   = ub_n_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl (WAIT_CYCLES=2): records outputs per cycle after a
// request is raised in cycle 0 and compares against hand-computed timing.
module tb_lc3_mem_ctrl;

    logic        Clk;
    logic        Reset;
    logic        MEM_RD;
    logic        MEM_WE;
    logic [15:0] MAR_addr;
    logic [15:0] MDR_val;
    logic [15:0] Switches;
    logic [15:0] Data_to_CPU;
    logic        R;
    logic [15:0] Hex_out;
    logic [19:0] sram_addr;
    logic [15:0] sram_din;
    logic [15:0] sram_dout;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    int n_tests;
    int n_fail;

    logic [19:0] l_addr [0:19];
    logic [15:0] l_dout [0:19];
    logic [15:0] l_dcpu [0:19];
    logic [15:0] l_hex  [0:19];
    logic        l_r    [0:19];
    logic        l_ce   [0:19];
    logic        l_oe   [0:19];
    logic        l_we   [0:19];
    logic        l_dq   [0:19];

    lc3_mem_ctrl #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF), .SRAM_AW(20)) dut (
        .Clk(Clk), .Reset(Reset), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE),
        .MAR_addr(MAR_addr), .MDR_val(MDR_val), .Switches(Switches),
        .Data_to_CPU(Data_to_CPU), .R(R), .Hex_out(Hex_out),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Cycle 0 is the cycle the caller has just raised the request in.
    task automatic record(input int n, input int drop_at);
        for (int c = 0; c < n; c++) begin
            if (c == 1) begin
                MAR_addr = 16'hDEAD;
                MDR_val  = 16'h0BAD;
            end
            if (c == drop_at) begin
                MEM_RD = 1'b0;
                MEM_WE = 1'b0;
            end
            @(negedge Clk);
            l_addr[c] = sram_addr;
            l_dout[c] = sram_dout;
            l_dcpu[c] = Data_to_CPU;
            l_hex[c]  = Hex_out;
            l_r[c]    = R;
            l_ce[c]   = sram_ce_n;
            l_oe[c]   = sram_oe_n;
            l_we[c]   = sram_we_n;
            l_dq[c]   = sram_dq_oe;
            step();
        end
    endtask

    task automatic release_req();
        MEM_RD = 1'b0;
        MEM_WE = 1'b0;
        step();
        step();
    endtask

    initial begin
        int cnt;
        n_tests  = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        MEM_RD   = 1'b0;
        MEM_WE   = 1'b0;
        MAR_addr = 16'h0000;
        MDR_val  = 16'h0000;
        Switches = 16'h0000;
        sram_din = 16'h0000;
        step();
        step();
        Reset = 1'b0;
        step();

        // 1: reset state
        @(negedge Clk);
        check("rst_n_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        check("rst_r", {31'd0, R}, 32'd0);
        check("rst_hex", {16'd0, Hex_out}, 32'd0);
        check("rst_dcpu", {16'd0, Data_to_CPU}, 32'd0);
        check("rst_dq_addr", {11'd0, sram_dq_oe, sram_addr}, 32'd0);
        step();

        // 2: SRAM read
        sram_din = 16'h1234; MAR_addr = 16'h0012; MEM_RD = 1'b1;
        record(6, 99);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("rd_oe_c%0d", c), {31'd0, l_oe[c]}, (c >= 1 && c <= 3) ? 32'd0 : 32'd1);
            check($sformatf("rd_r_c%0d", c), {31'd0, l_r[c]}, (c == 4) ? 32'd1 : 32'd0);
        end
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("rd_addr_c%0d", c), {12'd0, l_addr[c]}, 32'h00012);
            check($sformatf("rd_ce_c%0d", c), {31'd0, l_ce[c]}, 32'd0);
        end
        check("rd_data", {16'd0, l_dcpu[4]}, 32'h1234);
        release_req();

        // 3: SRAM write, Data_to_CPU must stay at x1234
        MAR_addr = 16'h0005; MDR_val = 16'hBEEF; MEM_WE = 1'b1;
        record(6, 99);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("wr_we_c%0d", c), {31'd0, l_we[c]}, (c == 2 || c == 3) ? 32'd0 : 32'd1);
            check($sformatf("wr_dq_c%0d", c), {31'd0, l_dq[c]}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            check($sformatf("wr_r_c%0d", c), {31'd0, l_r[c]}, (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("wr_oe_c%0d", c), {31'd0, l_oe[c]}, 32'd1);
        end
        check("wr_dout_c2", {16'd0, l_dout[2]}, 32'hBEEF);
        check("wr_dout_c3", {16'd0, l_dout[3]}, 32'hBEEF);
        check("wr_addr_c2", {12'd0, l_addr[2]}, 32'h00005);
        check("wr_dcpu", {16'd0, l_dcpu[4]}, 32'h1234);
        release_req();

        // 4: I/O write then I/O read
        MAR_addr = 16'hFFFF; MDR_val = 16'h00A5; MEM_WE = 1'b1;
        record(4, 99);
        check("iow_r_c1", {31'd0, l_r[1]}, 32'd1);
        check("iow_r_c2", {31'd0, l_r[2]}, 32'd0);
        check("iow_hex", {16'd0, l_hex[1]}, 32'h00A5);
        check("iow_dcpu", {16'd0, l_dcpu[1]}, 32'h1234);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("iow_ce_c%0d", c), {30'd0, l_ce[c], l_we[c]}, 32'd3);
            check($sformatf("iow_dq_c%0d", c), {31'd0, l_dq[c]}, 32'd0);
        end
        release_req();
        Switches = 16'h003C; MAR_addr = 16'hFFFF; MEM_RD = 1'b1;
        record(4, 99);
        check("ior_r_c1", {31'd0, l_r[1]}, 32'd1);
        check("ior_data", {16'd0, l_dcpu[1]}, 32'h003C);
        check("ior_hex", {16'd0, l_hex[1]}, 32'h00A5);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("ior_ce_c%0d", c), {30'd0, l_ce[c], l_oe[c]}, 32'd3);
        end
        release_req();

        // 5: MEM_RD held for 10 cycles past R gives one pulse only
        sram_din = 16'h5678; MAR_addr = 16'h0020; MEM_RD = 1'b1;
        record(15, 99);
        cnt = 0;
        for (int c = 0; c < 15; c++) cnt += int'(l_r[c]);
        check("hold_r_count", cnt, 32'd1);
        check("hold_r_c4", {31'd0, l_r[4]}, 32'd1);
        check("hold_data", {16'd0, l_dcpu[14]}, 32'h5678);
        MEM_RD = 1'b0;
        step();
        sram_din = 16'h4321; MAR_addr = 16'h0021; MEM_RD = 1'b1;
        record(6, 99);
        check("rerd_r_c4", {31'd0, l_r[4]}, 32'd1);
        check("rerd_addr", {12'd0, l_addr[1]}, 32'h00021);
        check("rerd_data", {16'd0, l_dcpu[4]}, 32'h4321);
        release_req();

        // Both requests high: the write wins and read data stays put
        MAR_addr = 16'h0033; MDR_val = 16'h7777; MEM_WE = 1'b1; MEM_RD = 1'b1;
        record(6, 99);
        check("both_we_c2", {31'd0, l_we[2]}, 32'd0);
        check("both_oe_c2", {31'd0, l_oe[2]}, 32'd1);
        check("both_dout", {16'd0, l_dout[2]}, 32'h7777);
        check("both_dcpu", {16'd0, l_dcpu[4]}, 32'h4321);
        release_req();

        // Request dropped in cycle 2: access still completes
        sram_din = 16'hA1B2; MAR_addr = 16'h0044; MEM_RD = 1'b1;
        record(6, 2);
        check("drop_r_c4", {31'd0, l_r[4]}, 32'd1);
        check("drop_data", {16'd0, l_dcpu[4]}, 32'hA1B2);
        check("drop_addr", {12'd0, l_addr[3]}, 32'h00044);
        release_req();

        // 6: reset in the second WAIT cycle of a write
        MAR_addr = 16'h0030; MDR_val = 16'h1111; MEM_WE = 1'b1;
        step();
        step();
        step();
        @(negedge Clk);
        check("rstw_we_c3", {31'd0, sram_we_n}, 32'd0);
        Reset = 1'b1;
        MEM_WE = 1'b0;
        step();
        @(negedge Clk);
        check("rstw_we", {31'd0, sram_we_n}, 32'd1);
        check("rstw_dq", {31'd0, sram_dq_oe}, 32'd0);
        check("rstw_r", {31'd0, R}, 32'd0);
        check("rstw_ce", {31'd0, sram_ce_n}, 32'd1);
        Reset = 1'b0;
        step();
        @(negedge Clk);
        check("rstw_r_after", {31'd0, R}, 32'd0);
        step();
        sram_din = 16'h9ABC; MAR_addr = 16'h0040; MEM_RD = 1'b1;
        record(6, 99);
        check("post_rst_r_c3", {31'd0, l_r[3]}, 32'd0);
        check("post_rst_r_c4", {31'd0, l_r[4]}, 32'd1);
        check("post_rst_data", {16'd0, l_dcpu[4]}, 32'h9ABC);
        check("post_rst_addr", {12'd0, l_addr[2]}, 32'h00040);
        release_req();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
